// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//             registers for the Execute stage. The result is computed in the
//             start cycle, held in pending registers, and committed to HI/LO
//             when the busy window expires.
//  Revision : 1.0  initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  multctrl,
  input  logic        start,
  input  logic [1:0]  we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW           = $clog2(c_MAX_CYCLES + 1);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pwr_q, pwr_d;   // pending result is committed (cleared on divide-by-zero)

  // Arithmetic, evaluated every cycle on the forwarded operands.
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_sq_u, w_sr_u, w_sq, w_sr;
  logic [31:0] w_uq, w_ur;
  logic        w_dz;

  assign w_prod_s = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
  assign w_prod_u = {32'd0, D1} * {32'd0, D2};
  assign w_dz     = (D2 == 32'd0);

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  assign w_abs_a = D1[31] ? (~D1 + 32'd1) : D1;
  assign w_abs_b = D2[31] ? (~D2 + 32'd1) : D2;
  assign w_sq_u  = w_dz ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_sr_u  = w_dz ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_sq    = (D1[31] ^ D2[31]) ? (~w_sq_u + 32'd1) : w_sq_u;
  assign w_sr    = D1[31] ? (~w_sr_u + 32'd1) : w_sr_u;
  assign w_uq    = w_dz ? 32'd0 : (D1 / D2);
  assign w_ur    = w_dz ? 32'd0 : (D1 % D2);

  // State, counter, HI/LO and pending-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  // Next-state: launch in idle, count down while busy, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // start always suppresses mthi/mtlo, even with an invalid op
          unique case (multctrl)
            c_OP_MULT: begin
              phi_d   = w_prod_s[63:32];
              plo_d   = w_prod_s[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            c_OP_MULTU: begin
              phi_d   = w_prod_u[63:32];
              plo_d   = w_prod_u[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            c_OP_DIV: begin
              phi_d   = w_sr;
              plo_d   = w_sq;
              pwr_d   = !w_dz;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            c_OP_DIVU: begin
              phi_d   = w_ur;
              plo_d   = w_uq;
              pwr_d   = !w_dz;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            default: ;
          endcase
        end else begin
          if (we == 2'd1) hi_d = D1;
          if (we == 2'd2) lo_d = D1;
        end
      end
      S_BUSY: begin
        if (cnt_q <= CW'(1)) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          pwr_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Self-checking bench for md_unit: table of operations plus
//             hand-written corner sequences; results flow through a queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D1, D2;
  logic [2:0]  multctrl;
  logic        start;
  logic [1:0]  we;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .D1(D1), .D2(D2), .multctrl(multctrl),
    .start(start), .we(we), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;   // bench model of architectural HI/LO
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, watch the busy window, then score the commit.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int ncyc, input bit disturb);
    exp_t e;
    int   n;
    multctrl = op; D1 = a; D2 = b; start = 1'b1; we = 2'd0;
    e.hi = eh; e.lo = el;
    sb.push_back(e);
    tick();
    start = 1'b0; multctrl = 3'd0; D1 = 32'd0; D2 = 32'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk("hold_hi", hi, m_hi);
      chk("hold_lo", lo, m_lo);
      if (disturb && n == 2) begin
        we = 2'd2; start = 1'b1; multctrl = 3'd4; D1 = 32'hDEAD; D2 = 32'd1;
      end else begin
        we = 2'd0; start = 1'b0; multctrl = 3'd0; D1 = 32'd0; D2 = 32'd0;
      end
      tick();
    end
    we = 2'd0; start = 1'b0; multctrl = 3'd0;
    chk("busy_cycles", 32'(n), 32'(ncyc));
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("result_hi", hi, e.hi);
      chk("result_lo", lo, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    tbl[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[5] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tbl[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[7] = '{3'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    reset = 1'b1; D1 = 32'd0; D2 = 32'd0; multctrl = 3'd0; start = 1'b0; we = 2'd0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // Table of operations
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].eh, tbl[i].el,
             (tbl[i].op <= 3'd2) ? 5 : 10, 1'b0);
    end

    // mthi then mtlo, zero latency
    D1 = 32'hABCD; we = 2'd1; tick();
    chk("mthi", hi, 32'hABCD); m_hi = 32'hABCD;
    D1 = 32'h22; we = 2'd2; tick();
    chk("mtlo", lo, 32'h22); m_lo = 32'h22;
    D1 = 32'h11; we = 2'd1; tick();
    chk("mthi2", hi, 32'h11); m_hi = 32'h11;
    we = 2'd0;

    // divide by zero leaves HI/LO untouched
    run_op(3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10, 1'b0);

    // start with invalid op plus we: no launch, and we is suppressed
    multctrl = 3'd5; start = 1'b1; we = 2'd1; D1 = 32'h5555; tick();
    start = 1'b0; we = 2'd0; multctrl = 3'd0;
    chk("inv_start_busy", 32'(busy), 32'd0);
    chk("inv_start_hi", hi, 32'h11);

    // mtlo and a new start while busy are both ignored
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1);

    // reset in the third busy cycle of a div aborts it
    multctrl = 3'd3; D1 = 32'd100; D2 = 32'd3; start = 1'b1; tick();
    start = 1'b0; multctrl = 3'd0;
    tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle integer multiply/divide unit for the Execute stage of the 5-stage MIPS pipeline.
- Accepts forwarded rs/rt operands together with a start pulse from the controller, and models the architectural HI/LO registers.
- Raises busy while an operation is in flight; the datapath uses busy and start to stall mult/div/mf/mt instructions in Decode.
- HI/LO outputs feed the Execute-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high after a mult/multu start.
- DIV_CYCLES, 10, number of cycles busy stays high after a div/divu start.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- D1  input  32  forwarded rs value (dividend / multiplicand, mthi/mtlo source).
- D2  input  32  forwarded rt value (divisor / multiplier).
- multctrl  input  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu; 5-7 treated as none.
- start  input  1  one-cycle pulse; launches the operation in multctrl this cycle.
- we  input  2  HI/LO direct write: 0 none, 1 mthi (HI<=D1), 2 mtlo (LO<=D1), 3 treated as none.
- busy  output  1  high while an operation is in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, cycle counter=0, pending results=0. Reset mid-operation aborts the operation; nothing is committed.
- Idle state (busy=0):
  - start=1 with a valid multctrl: compute the result from D1/D2 this cycle and latch it into the pending HI/LO registers. Load the counter with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
  - start=1 with multctrl none or invalid: no effect.
- Busy state: the counter decrements each cycle. When it reaches 1, that edge commits pending to hi/lo, sets busy=0 and clears the counter.
  - Result: busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - New hi/lo are visible in the first cycle that busy=0.
- hi/lo hold their old values throughout busy.
- mult: signed 32x32->64; hi=product[63:32], lo=product[31:0].
- multu: same as mult, unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (D2=0, div or divu): busy still runs DIV_CYCLES cycles; hi and lo are left unchanged at commit.
- we (mthi/mtlo): writes D1 on the next edge with zero latency. Only acts when busy=0 and start=0; otherwise ignored.
- Simultaneous start and we: start wins; we is ignored.
- start while busy=1: ignored, and the in-flight operation is unaffected. The pipeline stall normally prevents this.
- Combinational paths: busy, hi and lo are register outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset → hi=0, lo=0, busy=0.
- mult, D1=0xFFFFFFFE (-2), D2=3, start for 1 cycle → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. During busy, hi/lo hold their prior values.
- multu, D1=0xFFFFFFFF, D2=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div, D1=-7 (0xFFFFFFF9), D2=2 → busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu, D1=7, D2=0, with prior hi=0x11, lo=0x22 → busy for 10 cycles; afterwards hi=0x11, lo=0x22 (unchanged).
- Edge cases:
  - we=1, D1=0xABCD → hi=0xABCD next cycle.
  - we=2 asserted while busy → lo unchanged.
  - reset asserted in cycle 3 of a div → busy=0, hi=0, lo=0 the next cycle; no later commit.
